// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared ALU arbiter constants, FSM states and index-width helper
package alu_share_pkg;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_LUI = 4'b0000;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/alu_share_grant.sv
// alu_share_grant: combinational grant select, first valid requester searching upward from ptr
module alu_share_grant #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    int   k;
    logic found;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[k]) begin
                grant[k] = 1'b1;
                idx      = IW'(k);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU among NUM_REQ requesters via valid/ready
// handshakes; fixed priority by default, round-robin when ALU_ARB_ROUND_ROBIN_EN is defined
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_data_o,
    output logic                           rsp_zero_o,
    output logic [OP_WIDTH-1:0]            alu_operation_o,
    output logic [DATA_WIDTH-1:0]          alu_a_o,
    output logic [DATA_WIDTH-1:0]          alu_b_o,
    input  logic [DATA_WIDTH-1:0]          alu_data_i,
    input  logic                           alu_zero_i
);
    localparam int IW = clog2(NUM_REQ);
    state_t             state;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      ptr;
    logic [NUM_REQ-1:0] sel;
    logic [IW-1:0]      sel_idx;

    alu_share_grant #(.NUM_REQ(NUM_REQ), .IW(IW)) u_grant (
        .valid (req_valid_i),
        .ptr   (ptr),
        .grant (sel),
        .idx   (sel_idx)
    );

    assign req_ready_o = (state == IDLE && !reset) ? sel : '0;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // ptr holds the next search start, one past the last accepted index
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (state == IDLE && |req_valid_i)
            ptr <= (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            gnt_idx         <= '0;
            rsp_valid_o     <= '0;
            rsp_data_o      <= '0;
            rsp_zero_o      <= 1'b0;
            alu_operation_o <= '0;
            alu_a_o         <= '0;
            alu_b_o         <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid_i) begin
                    alu_operation_o <= req_op_i[sel_idx*OP_WIDTH +: OP_WIDTH];
                    alu_a_o         <= req_a_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    alu_b_o         <= req_b_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                    gnt_idx         <= sel_idx;
                    state           <= EXEC;
                end
                EXEC: begin
                    rsp_data_o  <= alu_data_i;
                    rsp_zero_o  <= alu_zero_i;
                    rsp_valid_o <= NUM_REQ'(1) << gnt_idx;
                    state       <= RESP;
                end
                RESP: if (rsp_ready_i[gnt_idx]) begin
                    rsp_valid_o <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a behavioural ALU model
module tb_alu_share_arbiter;
    logic        clk = 0;
    logic        reset;
    logic [1:0]  req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [7:0]  req_op_i;
    logic [63:0] req_a_i, req_b_i;
    logic [31:0] rsp_data_o, alu_a_o, alu_b_o, alu_data_i;
    logic        rsp_zero_o, alu_zero_i;
    logic [3:0]  alu_operation_o;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_data_i = (alu_operation_o == 4'b0011) ? alu_a_o + alu_b_o :
                     (alu_operation_o == 4'b0001) ? (alu_a_o | alu_b_o) :
                     (alu_operation_o == 4'b0000) ? {alu_b_o[15:0], 16'h0} : 32'h0;
        alu_zero_i = (alu_data_i == 32'h0);
    end

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o),
        .alu_operation_o(alu_operation_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op_i[k*4 +: 4]  = op;
        req_a_i[k*32 +: 32] = a;
        req_b_i[k*32 +: 32] = b;
    endtask

    initial begin
        logic [1:0] exp_g;
        reset = 1;
        req_valid_i = 2'b01;
        rsp_ready_i = 2'b11;
        req_op_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        tick;
        tick;
        chk("reset_req_ready", req_ready_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_data", rsp_data_o, 0);
        chk("reset_alu_a", alu_a_o, 0);
        reset = 0;
        req_valid_i = 0;
        tick;

        // 1: req0 ADD 5+7
        set_req(0, 4'b0011, 32'd5, 32'd7);
        req_valid_i = 2'b01;
        #1 chk("t1_ready", req_ready_o, 2'b01);
        tick;
        req_valid_i = 0;
        chk("t1_exec_ready", req_ready_o, 0);
        chk("t1_exec_valid", rsp_valid_o, 0);
        chk("t1_alu_op", alu_operation_o, 4'b0011);
        chk("t1_alu_a", alu_a_o, 5);
        chk("t1_alu_b", alu_b_o, 7);
        tick;
        chk("t1_rsp_valid", rsp_valid_o, 2'b01);
        chk("t1_data", rsp_data_o, 12);
        chk("t1_zero", rsp_zero_o, 0);
        tick;
        chk("t1_done", rsp_valid_o, 0);

        // 2: req1 LUI
        set_req(1, 4'b0000, 32'h0, 32'h00001234);
        req_valid_i = 2'b10;
        #1 chk("t2_ready", req_ready_o, 2'b10);
        tick;
        req_valid_i = 0;
        tick;
        chk("t2_rsp_valid", rsp_valid_o, 2'b10);
        chk("t2_data", rsp_data_o, 32'h12340000);
        tick;

        // 3: both requesters held valid
        set_req(0, 4'b0001, 32'hF0, 32'h0F);
        set_req(1, 4'b0011, 32'd1, 32'd2);
        req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            #1 chk("t3_ready", req_ready_o, exp_g);
            tick;
            tick;
            chk("t3_rsp_valid", rsp_valid_o, exp_g);
            chk("t3_data", rsp_data_o, exp_g[0] ? 32'hFF : 32'd3);
            tick;
        end
        req_valid_i = 0;

        // 4: response back-pressure, zero result, non-granted ready ignored
        set_req(0, 4'b0011, 32'hFFFFFFFF, 32'd1);
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b01;
        tick;
        req_valid_i = 2'b10;
        rsp_ready_i = 2'b10;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", rsp_valid_o, 2'b01);
            chk("t4_hold_data", rsp_data_o, 0);
            chk("t4_hold_zero", rsp_zero_o, 1);
            chk("t4_hold_ready", req_ready_o, 0);
            tick;
        end
        rsp_ready_i = 2'b01;
        tick;
        chk("t4_released", rsp_valid_o, 0);
        chk("t4_idle_ready", req_ready_o, 2'b10);
        rsp_ready_i = 2'b11;
        tick;
        req_valid_i = 0;
        tick;
        chk("t4_req1_valid", rsp_valid_o, 2'b10);
        chk("t4_req1_data", rsp_data_o, 3);
        tick;

        // 5: reset during EXEC
        set_req(0, 4'b0011, 32'd5, 32'd7);
        req_valid_i = 2'b01;
        tick;
        req_valid_i = 0;
        #1 reset = 1;
        #1;
        chk("t5_alu_a", alu_a_o, 0);
        chk("t5_alu_op", alu_operation_o, 0);
        chk("t5_data", rsp_data_o, 0);
        chk("t5_valid", rsp_valid_o, 0);
        chk("t5_ready", req_ready_o, 0);
        tick;
        reset = 0;
        tick;
        chk("t5_no_rsp", rsp_valid_o, 0);
        set_req(1, 4'b0000, 32'h0, 32'h0000ABCD);
        req_valid_i = 2'b10;
        #1 chk("t5_new_ready", req_ready_o, 2'b10);
        tick;
        req_valid_i = 0;
        tick;
        chk("t5_new_valid", rsp_valid_o, 2'b10);
        chk("t5_new_data", rsp_data_o, 32'hABCD0000);
        tick;

        // 6: unsupported opcode
        set_req(0, 4'b0111, 32'd9, 32'd9);
        req_valid_i = 2'b01;
        tick;
        req_valid_i = 0;
        tick;
        chk("t6_valid", rsp_valid_o, 2'b01);
        chk("t6_data", rsp_data_o, 0);
        chk("t6_zero", rsp_zero_o, 1);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
